pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It sequences the F/D, D/E and E/M pipeline registers by driving their write-enable and flush inputs. Hazard detection uses the Tuse/Tnew method, applied to a shadow copy of the destination register and Tnew of the instructions in E and M. It also owns the multiply/divide busy counter and stalls HI/LO-dependent instructions in D until the unit is free.

---
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: Tuse/Tnew stall control for the F/D, D/E, E/M pipeline registers plus MDU busy countdown.
// Latency: all outputs are combinational from the E/M shadow state and the D-stage fields.
// Backpressure: a D-stage stall holds PC and F/D and pushes a bubble into D/E; E/M always advances.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md,
    input  logic       D_md_start,
    input  logic       D_md_div,
    output logic       stall,
    output logic       pc_we,
    output logic       fd_we,
    output logic       de_flush,
    output logic       em_we,
    output logic       em_flush,
    output logic       md_busy
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    // Shadow copies of the destination/Tnew of the instructions in E and M.
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic       e_md_start;
    logic       e_md_div;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic [3:0] cnt;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    // Register hazards: a producer still short of forwardable versus the consumer's deadline.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (D_rs != 5'd0) begin
            stall_rs = ((D_rs == e_a3) && (e_tnew > D_Tuse_rs)) ||
                       ((D_rs == m_a3) && (m_tnew > D_Tuse_rs));
        end
        if (D_rt != 5'd0) begin
            stall_rt = ((D_rt == e_a3) && (e_tnew > D_Tuse_rt)) ||
                       ((D_rt == m_a3) && (m_tnew > D_Tuse_rt));
        end
    end

    // MDU is busy from the cycle the start sits in E until the countdown reaches zero.
    always_comb begin
        md_busy  = e_md_start | (cnt != 4'd0);
        stall_md = D_md & md_busy;
        stall    = stall_rs | stall_rt | stall_md;
        pc_we    = ~stall;
        fd_we    = ~stall;
        de_flush = stall;
        em_we    = 1'b1;
        em_flush = 1'b0;
    end

    // Advance the shadow pipeline; a stalled D stage enters E as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3       <= 5'd0;
            e_tnew     <= 2'd0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_a3       <= 5'd0;
            m_tnew     <= 2'd0;
        end else begin
            if (stall) begin
                e_a3       <= 5'd0;
                e_tnew     <= 2'd0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_a3       <= D_A3;
                e_tnew     <= D_Tnew;
                e_md_start <= D_md_start & D_md;
                e_md_div   <= D_md_div;
            end
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
        end
    end

    // Busy countdown, loaded as the start instruction leaves E.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (e_md_start) begin
            cnt <= e_md_div ? DIV_LD : MULT_LD;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int HMAX     = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md, D_md_start, D_md_div;
    logic       stall, pc_we, fd_we, de_flush, em_we, em_flush, md_busy;

    pipe_hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_A3(D_A3), .D_Tnew(D_Tnew), .D_md(D_md), .D_md_start(D_md_start),
        .D_md_div(D_md_div),
        .stall(stall), .pc_we(pc_we), .fd_we(fd_we), .de_flush(de_flush),
        .em_we(em_we), .em_flush(em_flush), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // History of what was issued from D in each cycle; an instruction issued
    // in cycle i is in E during i+1 and in M during i+2, its Tnew shrinking by one per stage.
    int         cyc = 0;
    int         reset_cyc = -1;
    logic [4:0] iss_a3   [HMAX];
    int         iss_tnew [HMAX];
    int         md_s = -1;
    bit         md_is_div = 0;
    bit         en = 0;
    bit         m_stall, m_busy;

    function automatic bit reg_hazard(input int t, input logic [4:0] src, input int tuse);
        bit h = 0;
        if (src == 5'd0) return 0;
        for (int k = 1; k <= 2; k++) begin
            int i = t - k;
            int rem;
            if (i > reset_cyc && i >= 0) begin
                rem = iss_tnew[i] - (k - 1);
                if (rem < 0) rem = 0;
                if (iss_a3[i] == src && rem > tuse) h = 1;
            end
        end
        return h;
    endfunction

    function automatic bit model_busy(input int t);
        int len;
        if (md_s < 0 || md_s <= reset_cyc) return 0;
        len = md_is_div ? DIV_CYC : MULT_CYC;
        return (t >= md_s + 1) && (t <= md_s + 1 + len);
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        m_busy  = model_busy(cyc);
        m_stall = reg_hazard(cyc, D_rs, int'(D_Tuse_rs)) |
                  reg_hazard(cyc, D_rt, int'(D_Tuse_rt)) |
                  (D_md & m_busy);
        if (en) begin
            chk("stall",    int'(stall),    int'(m_stall));
            chk("pc_we",    int'(pc_we),    int'(!m_stall));
            chk("fd_we",    int'(fd_we),    int'(!m_stall));
            chk("de_flush", int'(de_flush), int'(m_stall));
            chk("em_we",    int'(em_we),    1);
            chk("em_flush", int'(em_flush), 0);
            chk("md_busy",  int'(md_busy),  int'(m_busy));
        end
    end

    // Record what the clock edge commits.
    always @(posedge clk) begin
        if (cyc < HMAX) begin
            iss_a3[cyc]   = 5'd0;
            iss_tnew[cyc] = 0;
        end
        if (reset) begin
            reset_cyc = cyc;
            en = 1;
        end else if (!m_stall && cyc < HMAX) begin
            iss_a3[cyc]   = D_A3;
            iss_tnew[cyc] = int'(D_Tnew);
            if (D_md && D_md_start) begin
                md_s = cyc;
                md_is_div = D_md_div;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- stimulus ----------------
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic md, input logic mds, input logic mdd);
        D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
        D_A3 = a3; D_Tnew = tnew; D_md = md; D_md_start = mds; D_md_div = mdd;
    endtask

    task automatic nop(input int n);
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Hold an instruction in D until it issues; return the number of stall cycles seen.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic md, input logic mds, input logic mdd,
                         output int nst);
        bit s;
        nst = 0;
        set_d(rs, rt, tu_rs, tu_rt, a3, tnew, md, mds, mdd);
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            s = stall;
            @(posedge clk); #1;
            if (!s) return;
            nst++;
        end
        chk("issue_timeout", 1, 0);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle outputs on the first cycle after reset.
        @(negedge clk);
        chk("rst_stall", int'(stall), 0);
        chk("rst_pc_we", int'(pc_we), 1);
        chk("rst_fd_we", int'(fd_we), 1);
        chk("rst_de_flush", int'(de_flush), 0);
        chk("rst_em_we", int'(em_we), 1);
        chk("rst_em_flush", int'(em_flush), 0);
        chk("rst_md_busy", int'(md_busy), 0);
        @(posedge clk); #1;

        // lw r8 -> add r8 (Tuse 1): one stall cycle
        issue(0, 0, 3, 3, 8, 2, 0, 0, 0, n);
        issue(8, 0, 1, 3, 9, 1, 0, 0, 0, n);
        chk("load_use_stalls", n, 1);
        nop(3);

        // lw r8 -> nop -> use r8 at Tuse 0: M-stage hazard, one stall
        issue(0, 0, 3, 3, 8, 2, 0, 0, 0, n);
        nop(1);
        issue(8, 0, 0, 3, 0, 0, 0, 0, 0, n);
        chk("load_m_stage_stalls", n, 1);
        nop(3);

        // addu r9 -> beq rt=r9 Tuse 0: one stall
        issue(0, 0, 3, 3, 9, 1, 0, 0, 0, n);
        issue(0, 9, 3, 0, 0, 0, 0, 0, 0, n);
        chk("alu_branch_stalls", n, 1);
        nop(3);

        // addu r9 -> rt=r9 Tuse 1: no stall
        issue(0, 0, 3, 3, 9, 1, 0, 0, 0, n);
        issue(0, 9, 3, 1, 0, 0, 0, 0, 0, n);
        chk("alu_tuse1_stalls", n, 0);
        nop(3);

        // lw r8 -> consumer with Tuse 3 (unused): no stall
        issue(0, 0, 3, 3, 8, 2, 0, 0, 0, n);
        issue(8, 8, 3, 3, 0, 0, 0, 0, 0, n);
        chk("tuse3_stalls", n, 0);
        nop(3);

        // lw to r0 -> add rs=r0 Tuse 0: no stall
        issue(0, 0, 3, 3, 0, 2, 0, 0, 0, n);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, n);
        chk("r0_stalls", n, 0);
        nop(3);

        // mult -> mfhi: 1+MULT_CYC stall cycles, busy drops as mfhi issues
        issue(1, 2, 0, 0, 0, 0, 1, 1, 0, n);
        issue(0, 0, 3, 3, 4, 1, 1, 0, 0, n);
        chk("mult_mfhi_stalls", n, 6);
        chk("mult_busy_after", int'(md_busy), 0);
        nop(3);

        // div -> mflo: 1+DIV_CYC stall cycles
        issue(1, 2, 0, 0, 0, 0, 1, 1, 1, n);
        issue(0, 0, 3, 3, 4, 1, 1, 0, 0, n);
        chk("div_mflo_stalls", n, 11);
        nop(3);

        // Simultaneous register + MDU hazard: lw r5 then mult reading r5 while a div runs
        issue(1, 2, 0, 0, 0, 0, 1, 1, 1, n);
        issue(0, 0, 3, 3, 5, 2, 0, 0, 0, n);
        issue(5, 0, 1, 3, 0, 0, 1, 1, 0, n);
        chk("combined_stalls", n, 10);
        nop(8);

        // div -> mflo with reset during the 4th busy cycle
        issue(1, 2, 0, 0, 0, 0, 1, 1, 1, n);
        set_d(0, 0, 3, 3, 4, 1, 1, 0, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("div_busy4", int'(md_busy), 1);
        chk("div_stall4", int'(stall), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(md_busy), 0);
        chk("midrst_stall", int'(stall), 0);
        @(posedge clk); #1;
        nop(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
